// File: rtl/adc1xmt.sv
// Purpose: 6-bit parallel-to-serial ADC-link emulator with frame marker, pattern modes and bitslip.
// Latency: a word loaded on edge t shows bit5 on DOUT after edge t+1 and bit0 after edge t+6.
// Backpressure: DREADY pulses once per word boundary in data mode; a missing word sends IDLE and counts UNDERFLOW.
module adc1xmt #(
    parameter logic [5:0] IDLE  = 6'b000000,
    parameter logic [5:0] TRAIN = 6'b111000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE,
    input  logic [5:0] DIN,
    input  logic       DVALID,
    output logic       DREADY,
    input  logic       SLIP,
    output logic       DOUT,
    output logic       FRAME,
    output logic [7:0] UNDERFLOW
);

    localparam logic [1:0] MODE_DATA  = 2'd0;
    localparam logic [1:0] MODE_TRAIN = 2'd1;
    localparam logic [1:0] MODE_RAMP  = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;
    localparam logic [5:0] ALT_WORD   = 6'b101010;
    localparam logic [2:0] BC_LAST    = 3'd5;

    logic [2:0] bc_q, bc_d;
    logic [5:0] sr_q, sr_d;
    logic [5:0] r_q, r_d;
    logic       pend_q, pend_d;
    logic       dout_q, dout_d;
    logic       frame_q, frame_d;
    logic [7:0] uf_q, uf_d;

    logic       at_last;
    logic       boundary;
    logic       stretch;
    logic [5:0] next_word;

    // Word-grid decode: the last bit slot either ends the word or, with a slip pending, is repeated once.
    always_comb begin
        at_last  = (bc_q == BC_LAST);
        boundary = at_last && !pend_q;
        stretch  = at_last && pend_q;
        DREADY   = boundary && (MODE == MODE_DATA);
    end

    // Select the word to load at the next boundary from the current MODE.
    always_comb begin
        next_word = IDLE;
        case (MODE)
            MODE_DATA:  next_word = DVALID ? DIN : IDLE;
            MODE_TRAIN: next_word = TRAIN;
            MODE_RAMP:  next_word = r_q;
            MODE_ALT:   next_word = ALT_WORD;
            default:    next_word = IDLE;
        endcase
    end

    // Next-state logic for the bit counter, shifter, ramp, slip flag, underflow count and output stage.
    always_comb begin
        bc_d    = bc_q + 3'd1;
        sr_d    = {sr_q[4:0], 1'b0};
        r_d     = r_q;
        uf_d    = uf_q;
        // A SLIP in the stretch cycle itself re-arms the flag for the following word.
        pend_d  = SLIP || (pend_q && !at_last);
        dout_d  = sr_q[5];
        // FRAME is aligned to DOUT: high while bits 5..3 are on the wire, low in the stretch slot.
        frame_d = (bc_q < 3'd3);

        if (boundary) begin
            bc_d = 3'd0;
            sr_d = next_word;
            if (MODE == MODE_RAMP) begin
                r_d = r_q + 6'd1;
            end
            if ((MODE == MODE_DATA) && !DVALID && (uf_q != 8'hff)) begin
                uf_d = uf_q + 8'd1;
            end
        end else if (stretch) begin
            bc_d = bc_q;
            sr_d = sr_q;
        end
    end

    // State registers; reset aborts any word in flight immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bc_q    <= 3'd0;
            sr_q    <= 6'd0;
            r_q     <= 6'd0;
            pend_q  <= 1'b0;
            dout_q  <= 1'b0;
            frame_q <= 1'b0;
            uf_q    <= 8'd0;
        end else begin
            bc_q    <= bc_d;
            sr_q    <= sr_d;
            r_q     <= r_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
            uf_q    <= uf_d;
        end
    end

    assign DOUT      = dout_q;
    assign FRAME     = frame_q;
    assign UNDERFLOW = uf_q;

endmodule

// File: doc/adc1xmt.md
# adc1xmt

Single-lane 6-bit serial transmitter: the transmit end of the per-channel ADC serial link. It converts 6-bit parallel words into a bit-serial stream with a frame marker, one bit per CLK cycle. It is used as an ADC emulator on the test/loopback path so the channel receiver's alignment logic (delay scan, bitslip) can be exercised against known patterns. It also supplies data from fabric through a ready/valid handshake.

## Interface
- IDLE, default 6'b000000, word transmitted in data mode when no input word is available (underflow).
- TRAIN, default 6'b111000, training pattern word (mode 1).
- CLK  in  1  bit clock; one serial bit per rising edge.
- RST  in  1  reset; asynchronous, active-high.
- MODE  in  2  pattern select: 0 data, 1 TRAIN, 2 ramp, 3 alternating 6'b101010.
- DIN  in  6  parallel word for data mode, DIN[5] sent first.
- DVALID  in  1  DIN valid.
- DREADY  out  1  transmitter takes DIN this cycle if DVALID.
- SLIP  in  1  single-cycle request to stretch the next word boundary by one bit.
- DOUT  out  1  serial data, registered.
- FRAME  out  1  frame marker, registered; high during bits 5..3 of each word, low during bits 2..0.
- UNDERFLOW  out  8  saturating count of data-mode boundaries with no valid word.

## Operation
- Bit counter BC counts 0..5. Shift register SR is 6 bits. DOUT = SR[5] registered. SR shifts left each cycle, filling with 0.
- Word boundary: a cycle with BC==5 and no stretch pending. On a boundary, SR loads the next word and BC goes to 0. Otherwise BC increments.
- Next word, selected by MODE sampled at the boundary:
  - 0: DIN if DVALID, else IDLE, and UNDERFLOW increments, saturating at 255.
  - 1: TRAIN.
  - 2: ramp register R; R increments by 1 mod 64 after each load.
  - 3: 6'b101010.
- The ramp register keeps its value while not in mode 2 and resumes from it.
- DREADY = boundary && MODE==0 (combinational from registered BC and pending flag plus the MODE input). The transfer occurs when DVALID && DREADY. DIN is never sampled at other times.
- Slip:
  - A SLIP high in any cycle sets the pending flag. Multiple SLIPs before the flag is consumed collapse to one.
  - When BC==5 with the flag set, that cycle becomes a stretch cycle:
    - no load;
    - BC stays 5;
    - DREADY=0;
    - SR holds, so DOUT repeats the previous word's last bit;
    - FRAME stays low;
    - the flag clears.
  - The following cycle is a normal boundary.
  - Net effect: the stream shifts one bit later relative to the word grid.
  - A SLIP asserted in the stretch cycle itself sets the flag again and applies at the next word's end.
- A MODE change mid-word does not affect the word in flight.

## Timing
- Reset values:
  - BC=0, SR=0, R=0, pending flag=0;
  - DOUT=0, FRAME=0, UNDERFLOW=0;
  - DREADY=0 until the first boundary.
- After RST deasserts, the first boundary occurs on the 6th rising edge (BC 0→5). Dummy zero bits go out before that boundary.
- Latency: a word loaded at edge t appears on DOUT as bit5 after edge t+1 and bit0 after edge t+6, back-to-back with no gaps.
- FRAME is registered in the same stage as DOUT, so FRAME high coincides exactly with bits 5,4,3 on DOUT.
- Throughput: one word per 6 cycles. A stretch costs exactly 1 cycle, giving 7 cycles for that word period.
- RST asserted mid-word aborts the word immediately (asynchronously). An accepted word not fully sent is lost. UNDERFLOW clears.

## Test plan
- Mode 0, DVALID held high, DIN = 6'b110100 then 6'b001011 on successive DREADY -> DOUT stream 1,1,0,1,0,0,0,0,1,0,1,1. FRAME 1,1,1,0,0,0 repeating. DREADY is one cycle in six.
- Mode 0, DVALID low for 300 boundaries -> DOUT carries IDLE words. UNDERFLOW reaches 255 and holds. RST -> UNDERFLOW=0, DOUT=0, FRAME=0.
- Mode 2 from reset for 70 words -> decoded words 0,1,…,63,0,…,5. A switch to mode 1 and back to mode 2 resumes from the held value.
- Mode 1, single SLIP pulse mid-word -> the word boundary is delayed by exactly 1 cycle, the last 0 of 111000 is repeated once, and subsequent words are shifted by one bit. Two SLIPs in the same word give the same result as one.
- Mode 3, MODE changed to 1 at BC==2 -> the current 101010 completes unchanged. The next word is 111000.
- Mode 0, DVALID toggling randomly, scoreboard of accepted DIN vs. deserialized DOUT (FRAME-aligned) -> every accepted word is transmitted in order. Every non-accepted boundary sends IDLE and increments UNDERFLOW.
